// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port VRAM between VGA scan-out and a CPU.
// Display fetches own every active pixel tick; the CPU gets the remaining
// cycles through a req/ack handshake (write: ack with grant, read: ack one
// clk later, then one gap cycle). The frame buffer is down-scaled by
// 2^SCALE_SHIFT in both directions.
// Optional feature macro: VGA_ARB_CONFLICT_CNT_EN adds a 16-bit saturating
// count of CPU requests blocked by display slots (cleared on vsync_in rise).
module vga_vram_arbiter #(
  parameter  int SCALE_SHIFT = 2,
  parameter  int DW          = 12,
  localparam int AW          = 2 * (10 - SCALE_SHIFT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] rgb,
  output logic          hsync,
  output logic          vsync
`ifdef VGA_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_RET = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  state_t        r_state;
  tag_t          r_tag;
  logic [AW-1:0] r_addr_hold;
  logic [DW-1:0] r_wdata_hold;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_rgb;
  logic          r_von_tick;
  logic          r_hsync;
  logic          r_vsync;

  logic          w_disp;
  logic          w_grant;
  logic          w_rd_ret;
  logic [AW-1:0] w_disp_addr;
  logic          w_unused_pix;

  // Low pixel bits select a position inside a scaled block and are dropped.
  assign w_unused_pix = ^{pixel_x, pixel_y};

  assign w_disp_addr = {pixel_y[9:SCALE_SHIFT], pixel_x[9:SCALE_SHIFT]};
  assign w_disp      = p_tick & video_on;
  // Display slots always win; the CPU is only granted from IDLE.
  assign w_grant     = ~reset & ~w_disp & (r_state == ST_IDLE) & cpu_req;
  // A read return is suppressed by reset so a discarded read never acks.
  assign w_rd_ret    = ~reset & (r_state == ST_RD_RET);

  assign rgb   = r_rgb;
  assign hsync = r_hsync;
  assign vsync = r_vsync;

  // VRAM port mux and CPU completion signalling for the current slot.
  always_comb begin
    ram_addr  = r_addr_hold;
    ram_we    = 1'b0;
    ram_wdata = r_wdata_hold;
    cpu_ack   = 1'b0;
    cpu_rdata = r_cpu_rdata;
    if (reset) begin
      ram_addr  = {AW{1'b0}};
      ram_wdata = {DW{1'b0}};
    end else if (w_disp) begin
      ram_addr = w_disp_addr;
    end else if (w_grant) begin
      ram_addr = cpu_addr;
      if (cpu_we) begin
        ram_we    = 1'b1;
        ram_wdata = cpu_wdata;
        cpu_ack   = 1'b1;
      end else begin
        ram_we = 1'b0;
      end
    end else begin
      ram_addr = r_addr_hold;
    end
    if (w_rd_ret) begin
      cpu_ack   = 1'b1;
      cpu_rdata = ram_rdata;
    end else begin
      cpu_rdata = r_cpu_rdata;
    end
  end

  // CPU access sequencer: IDLE -> (RD_RET ->) GAP -> IDLE, plus slot owner tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tag       <= TAG_NONE;
      r_cpu_rdata <= {DW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state <= cpu_we ? ST_GAP : ST_RD_RET;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_RET: begin
          r_cpu_rdata <= ram_rdata;
          r_state     <= ST_GAP;
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_disp) begin
        r_tag <= TAG_DISP;
      end else if (w_grant && !cpu_we) begin
        r_tag <= TAG_CPU;
      end else begin
        r_tag <= TAG_NONE;
      end
    end
  end

  // Hold the last driven address/data so idle cycles keep the VRAM port stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_hold  <= {AW{1'b0}};
      r_wdata_hold <= {DW{1'b0}};
    end else begin
      r_addr_hold  <= ram_addr;
      r_wdata_hold <= ram_wdata;
    end
  end

  // Pixel output: load fetched colour, hold between ticks, black in blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb      <= {DW{1'b0}};
      r_von_tick <= 1'b0;
    end else begin
      if (p_tick) begin
        r_von_tick <= video_on;
      end
      if (r_tag == TAG_DISP) begin
        r_rgb <= ram_rdata;
      end else if (!r_von_tick) begin
        r_rgb <= {DW{1'b0}};
      end
    end
  end

  // Sync delay stage to follow the registered pixel path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_hsync <= hsync_in;
      r_vsync <= vsync_in;
    end
  end

`ifdef VGA_ARB_CONFLICT_CNT_EN
  logic [15:0] r_conflict_cnt;
  logic        w_conflict;
  logic        w_vs_rise;

  assign w_conflict   = cpu_req & w_disp & (r_state == ST_IDLE);
  assign w_vs_rise    = vsync_in & ~r_vsync;
  assign conflict_cnt = r_conflict_cnt;

  // Saturating count of CPU requests blocked by display slots, per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= 16'd0;
    end else if (w_vs_rise) begin
      r_conflict_cnt <= 16'd0;
    end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Randomized bench for vga_vram_arbiter with a cycle-level reference model
// built from the arbitration rules (eligibility cycle, pending read, colour
// pipeline) and a shadow copy of VRAM.
module tb_vga_vram_arbiter;
  localparam int SS = 2;
  localparam int DW = 12;
  localparam int AW = 16;
  localparam int H_ACT = 40, H_TOT = 56, HS_B = 44, HS_E = 48;
  localparam int V_ACT = 8, V_TOT = 12, VS_B = 9, VS_E = 11;
  localparam int NCYC = 5600;

  logic clk = 1'b0;
  logic reset, p_tick, video_on, hsync_in, vsync_in;
  logic [9:0] pixel_x, pixel_y;
  logic cpu_req, cpu_we, cpu_ack, ram_we, hsync, vsync;
  logic [AW-1:0] cpu_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, ram_wdata, rgb;
  logic [DW-1:0] ram_rdata = 12'h000;
`ifdef VGA_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  vga_vram_arbiter #(.SCALE_SHIFT(SS), .DW(DW)) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rgb(rgb), .hsync(hsync), .vsync(vsync)
`ifdef VGA_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] sh_mem [0:(1<<AW)-1];

  // Synchronous single-port VRAM, one-cycle read latency.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // stimulus state
  int hc = 0, vc = 0, gap = 0, wait_cnt = 0, burst_left = 0, n_txn = 0;
  bit txn_valid = 0, first_burst = 0, rst_sched = 0, did_rst = 0, reset_now;
  int last_ack_cyc = -1, rst_cyc = -10;
  logic ack_prev = 1'b0;

  // reference model state
  int next_ok = 0;
  bit rd_pend = 0, f1_valid = 0, vlast = 0, disp, idle, grant;
  logic [DW-1:0] rd_val, m_rdata, m_rgb, f1_val, fetch_val, next_rgb;
  logic [AW-1:0] m_addr, e_addr;
  logic e_we, e_ack, hs_exp, vs_exp;
  int m_cc = 0;

  task automatic new_txn();
    int kind;
    txn_valid = 1;
    n_txn++;
    if (n_txn <= 10) begin
      cpu_we    = 1'b1;
      cpu_addr  = 16'h1234 + 16'(n_txn - 1);
      cpu_wdata = 12'h5A5 + 12'(n_txn - 1);
    end else begin
      kind      = $urandom_range(0, 2);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_wdata = 12'($urandom);
      if (kind == 0) cpu_addr = 16'h1234 + 16'($urandom_range(0, 9));
      else if (kind == 1) cpu_addr = {8'($urandom_range(0, 1)), 8'($urandom_range(0, 9))};
      else cpu_addr = 16'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = 12'($urandom);
      sh_mem[i] = mem[i];
    end
    mem[0] = 12'hABC;
    sh_mem[0] = 12'hABC;
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0;
    hsync_in = 1'b1; vsync_in = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 16'h0000; cpu_wdata = 12'h000;
    m_rdata = 12'h000; m_rgb = 12'h000; m_addr = 16'h0000; rd_val = 12'h000;
    f1_val = 12'h000; hs_exp = 1'b1; vs_exp = 1'b1;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      // ---- drive inputs for this cycle ----
      reset_now = (cyc < 3) || rst_sched;
      rst_sched = 0;
      reset     = reset_now;
      p_tick    = (cyc % 2) == 1;
      pixel_x   = 10'(hc);
      pixel_y   = 10'(vc);
      video_on  = (hc < H_ACT) && (vc < V_ACT);
      hsync_in  = !((hc >= HS_B) && (hc < HS_E));
      vsync_in  = !((vc >= VS_B) && (vc < VS_E));

      if (reset_now) begin
        cpu_req = 1'b0;
        gap = 2;
      end else if (cpu_req && ack_prev) begin
        if (first_burst) begin
          if (last_ack_cyc >= 0) chk("burst_ack_gap", cyc - 1 - last_ack_cyc, 2);
          last_ack_cyc = cyc - 1;
        end
        txn_valid = 0;
        if (burst_left > 0) begin
          burst_left--;
          new_txn();
          wait_cnt = 0;
        end else begin
          first_burst = 0;
          cpu_req = 1'b0;
          gap = $urandom_range(0, 5);
        end
      end else if (cpu_req) begin
        wait_cnt++;
        if (wait_cnt > 12) begin
          chk("ack_wait", wait_cnt, 12);
          cpu_req = 1'b0;
          txn_valid = 0;
        end
      end else if (cyc >= 84) begin
        if (gap > 0) gap--;
        else begin
          if (!txn_valid) begin
            if (n_txn == 0) begin
              first_burst = 1;
              burst_left = 9;
            end else begin
              burst_left = $urandom_range(0, 3);
            end
            new_txn();
          end
          cpu_req = 1'b1;
          wait_cnt = 0;
        end
      end

      #1;
      // ---- expected outputs for this cycle ----
      disp  = p_tick && video_on;
      idle  = cyc >= next_ok;
      grant = !reset_now && cpu_req && idle && !disp;
      e_we  = 1'b0;
      e_ack = 1'b0;
      if (reset_now) e_addr = 16'h0000;
      else if (disp) e_addr = {pixel_y[9:SS], pixel_x[9:SS]};
      else if (grant) e_addr = cpu_addr;
      else e_addr = m_addr;
      if (grant && cpu_we) begin
        e_we = 1'b1;
        e_ack = 1'b1;
      end
      if (!reset_now && rd_pend) e_ack = 1'b1;

      chk("ram_addr", ram_addr, e_addr);
      chk("ram_we", ram_we, e_we);
      chk("cpu_ack", cpu_ack, e_ack);
      if (e_we) chk("ram_wdata", ram_wdata, cpu_wdata);
      if (reset_now) chk("ram_wdata_rst", ram_wdata, 12'h000);
      if (!reset_now) begin
        if (rd_pend) m_rdata = rd_val;
        chk("cpu_rdata", cpu_rdata, m_rdata);
      end
      if (cyc > 0) begin
        chk("rgb", rgb, m_rgb);
        chk("hsync", hsync, hs_exp);
        chk("vsync", vsync, vs_exp);
`ifdef VGA_ARB_CONFLICT_CNT_EN
        chk("conflict_cnt", conflict_cnt, m_cc);
`endif
      end
      if (cyc >= 5 && cyc <= 12) chk("rgb_block0", rgb, 12'hABC);
      if (cyc == rst_cyc + 1) begin
        chk("rst_rdata", cpu_rdata, 12'h000);
        chk("rst_rgb", rgb, 12'h000);
      end
      ack_prev = reset_now ? 1'b0 : cpu_ack;

      // ---- advance reference model ----
`ifdef VGA_ARB_CONFLICT_CNT_EN
      if (reset_now) m_cc = 0;
      else if (vsync_in && !vs_exp) m_cc = 0;
      else if (cpu_req && idle && disp && m_cc < 65535) m_cc++;
`endif
      fetch_val = sh_mem[e_addr];
      next_rgb  = reset_now ? 12'h000 : (f1_valid ? f1_val : (vlast ? m_rgb : 12'h000));
      if (reset_now) vlast = 0;
      else if (p_tick) vlast = video_on;
      f1_valid = disp && !reset_now;
      f1_val   = fetch_val;
      m_rgb    = next_rgb;
      hs_exp   = reset_now ? 1'b1 : hsync_in;
      vs_exp   = reset_now ? 1'b1 : vsync_in;
      if (reset_now) begin
        next_ok = cyc + 1;
        rd_pend = 0;
        m_addr  = 16'h0000;
        m_rdata = 12'h000;
      end else begin
        m_addr  = e_addr;
        rd_pend = 0;
        if (grant) begin
          if (cpu_we) begin
            sh_mem[cpu_addr] = cpu_wdata;
            next_ok = cyc + 2;
          end else begin
            rd_pend = 1;
            rd_val  = sh_mem[cpu_addr];
            next_ok = cyc + 3;
            if (cyc > 2500 && !did_rst) begin
              rst_sched = 1;
              did_rst = 1;
              rst_cyc = cyc + 1;
            end
          end
        end
      end
      if (cyc >= 3 && p_tick) begin
        hc++;
        if (hc == H_TOT) begin
          hc = 0;
          vc = (vc + 1) % V_TOT;
        end
      end
    end
    if (!did_rst) chk("mid_read_reset_done", 32'(did_rst), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
